// File: rtl/apmu_irq_x_ctrl_if.sv
// Register-access bus between a core-side master and the interrupt controller.
// Every request completes with a single-cycle response on the following cycle.
interface apmu_irq_x_ctrl_if;
  logic        cfg_req;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_rvalid;
  logic [31:0] cfg_rdata;

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rvalid, cfg_rdata
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rvalid, cfg_rdata
  );
endinterface

// File: rtl/apmu_irq_x_ctrl.sv
// 32-source interrupt controller with per-bit edge/level detection, miss tracking
// and ack statistics, feeding the core's irq_x vector from registered state only.
module apmu_irq_x_ctrl #(
  parameter bit SyncInputs = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     irq_src_i,
  output logic [31:0]     irq_x_o,
  input  logic            irq_x_ack_i,
  input  logic [4:0]      irq_x_ack_id_i,
  apmu_irq_x_ctrl_if.slave cfg
);

  logic [31:0] src_q;
  logic [31:0] pending_q, pending_d;
  logic [31:0] enable_q, enable_d;
  logic [31:0] mode_q, mode_d;
  logic [31:0] missed_q, missed_d;
  logic [15:0] drop_q, drop_d;
  logic [31:0] ack_cnt_q, ack_cnt_d;
  logic [4:0]  last_id_q, last_id_d;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] s;
  logic [31:0] edge_vec;
  logic [31:0] ack_dec;
  logic [31:0] w1c_pend;
  logic [31:0] w1c_miss;
  logic [31:0] clr_vec;
  logic [31:0] miss_vec;
  logic        wr;

  if (SyncInputs) begin : g_sync
    logic [31:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= irq_src_i;
        sync2_q <= sync1_q;
      end
    end
    assign s = sync2_q;
  end else begin : g_nosync
    assign s = irq_src_i;
  end

  assign wr       = cfg.cfg_req & cfg.cfg_we;
  assign edge_vec = s & ~src_q;
  assign ack_dec  = irq_x_ack_i ? (32'd1 << irq_x_ack_id_i) : '0;
  assign w1c_pend = (wr && cfg.cfg_addr == 3'd1) ? cfg.cfg_wdata : '0;
  assign w1c_miss = (wr && cfg.cfg_addr == 3'd3) ? cfg.cfg_wdata : '0;
  assign clr_vec  = ack_dec | w1c_pend;
  // A miss only counts when the old pending bit survives this cycle's clears.
  assign miss_vec = mode_q & edge_vec & pending_q & ~clr_vec;

  always_comb begin
    pending_d = (mode_q & (edge_vec | (pending_q & ~clr_vec))) | (~mode_q & s);
    missed_d  = (missed_q & ~w1c_miss) | miss_vec;
    enable_d  = (wr && cfg.cfg_addr == 3'd0) ? cfg.cfg_wdata : enable_q;
    mode_d    = (wr && cfg.cfg_addr == 3'd2) ? cfg.cfg_wdata : mode_q;

    drop_d = drop_q;
    if (wr && cfg.cfg_addr == 3'd4)
      drop_d = '0;
    else if ((|miss_vec) && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;

    ack_cnt_d = ack_cnt_q;
    if (wr && cfg.cfg_addr == 3'd5)
      ack_cnt_d = '0;
    else if (irq_x_ack_i)
      ack_cnt_d = ack_cnt_q + 32'd1;

    last_id_d = irq_x_ack_i ? irq_x_ack_id_i : last_id_q;

    rdata_d = '0;
    if (cfg.cfg_req && !cfg.cfg_we) begin
      case (cfg.cfg_addr)
        3'd0:    rdata_d = enable_q;
        3'd1:    rdata_d = pending_q;
        3'd2:    rdata_d = mode_q;
        3'd3:    rdata_d = missed_q;
        3'd4:    rdata_d = {16'd0, drop_q};
        3'd5:    rdata_d = ack_cnt_q;
        3'd6:    rdata_d = {27'd0, last_id_q};
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '1;
      missed_q  <= '0;
      drop_q    <= '0;
      ack_cnt_q <= '0;
      last_id_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      src_q     <= s;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      missed_q  <= missed_d;
      drop_q    <= drop_d;
      ack_cnt_q <= ack_cnt_d;
      last_id_q <= last_id_d;
      rvalid_q  <= cfg.cfg_req;
      rdata_q   <= rdata_d;
    end
  end

  assign irq_x_o        = pending_q & enable_q;
  assign cfg.cfg_rvalid = rvalid_q;
  assign cfg.cfg_rdata  = rdata_q;

endmodule

// File: tb/tb_apmu_irq_x_ctrl.sv
// Drives an unsynchronized and a synchronized controller in lockstep and checks
// both against a per-cycle behavioural model of the register and pending rules.
module tb_apmu_irq_x_ctrl;

  typedef struct packed {
    logic [31:0] h1;
    logic [31:0] h2;
    logic [31:0] prevS;
    logic [31:0] pending;
    logic [31:0] enable;
    logic [31:0] mode;
    logic [31:0] missed;
    logic [15:0] drop;
    logic [31:0] ackCnt;
    logic [4:0]  lastId;
    logic        rvalid;
    logic [31:0] rdata;
  } ModelT;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src;
  logic        ackI;
  logic [4:0]  ackId;
  logic        cfgReq;
  logic        cfgWe;
  logic [2:0]  cfgAddr;
  logic [31:0] cfgWdata;
  logic [31:0] irq0, irq1;
  int          vectors = 0;
  int          miscompares = 0;
  ModelT       mdl [2];

  always #5 clk = ~clk;

  apmu_irq_x_ctrl_if cfg0 ();
  apmu_irq_x_ctrl_if cfg1 ();

  assign cfg0.cfg_req   = cfgReq;
  assign cfg0.cfg_we    = cfgWe;
  assign cfg0.cfg_addr  = cfgAddr;
  assign cfg0.cfg_wdata = cfgWdata;
  assign cfg1.cfg_req   = cfgReq;
  assign cfg1.cfg_we    = cfgWe;
  assign cfg1.cfg_addr  = cfgAddr;
  assign cfg1.cfg_wdata = cfgWdata;

  apmu_irq_x_ctrl #(.SyncInputs(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .irq_src_i(src), .irq_x_o(irq0),
    .irq_x_ack_i(ackI), .irq_x_ack_id_i(ackId), .cfg(cfg0)
  );

  apmu_irq_x_ctrl #(.SyncInputs(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .irq_src_i(src), .irq_x_o(irq1),
    .irq_x_ack_i(ackI), .irq_x_ack_id_i(ackId), .cfg(cfg1)
  );

  // One clock of the controller's rules; delay is the number of synchronizer stages.
  function automatic ModelT stepModel(input ModelT m, input int delay, input logic rstV,
                                      input logic [31:0] srcV, input logic ackV,
                                      input logic [4:0] idV, input logic reqV, input logic weV,
                                      input logic [2:0] addrV, input logic [31:0] wdV);
    ModelT       n;
    logic [31:0] sv;
    logic        wrV, anyMiss, edgeB, clr;
    n = m;
    if (rstV) begin
      n = '0;
      n.mode = '1;
      return n;
    end
    sv = (delay == 2) ? m.h2 : srcV;
    n.h2 = m.h1;
    n.h1 = srcV;
    n.prevS = sv;
    wrV = reqV && weV;
    anyMiss = 1'b0;
    n.rvalid = reqV;
    n.rdata = 32'd0;
    if (reqV && !weV) begin
      case (addrV)
        3'd0: n.rdata = m.enable;
        3'd1: n.rdata = m.pending;
        3'd2: n.rdata = m.mode;
        3'd3: n.rdata = m.missed;
        3'd4: n.rdata = {16'd0, m.drop};
        3'd5: n.rdata = m.ackCnt;
        3'd6: n.rdata = {27'd0, m.lastId};
        default: n.rdata = 32'd0;
      endcase
    end
    if (wrV && addrV == 3'd3) n.missed = m.missed & ~wdV;
    for (int i = 0; i < 32; i++) begin
      edgeB = sv[i] && !m.prevS[i];
      clr = (ackV && idV == i[4:0]) || (wrV && addrV == 3'd1 && wdV[i]);
      if (m.mode[i]) begin
        if (edgeB) begin
          if (m.pending[i] && !clr) begin
            n.missed[i] = 1'b1;
            anyMiss = 1'b1;
          end
          n.pending[i] = 1'b1;
        end else if (clr) begin
          n.pending[i] = 1'b0;
        end
      end else begin
        n.pending[i] = sv[i];
      end
    end
    if (wrV && addrV == 3'd0) n.enable = wdV;
    if (wrV && addrV == 3'd2) n.mode = wdV;
    if (wrV && addrV == 3'd4) n.drop = 16'd0;
    else if (anyMiss && m.drop != 16'hFFFF) n.drop = m.drop + 16'd1;
    if (wrV && addrV == 3'd5) n.ackCnt = 32'd0;
    else if (ackV) n.ackCnt = m.ackCnt + 32'd1;
    if (ackV) n.lastId = idV;
    return n;
  endfunction

  always @(posedge clk) begin
    mdl[0] <= stepModel(mdl[0], 0, rst, src, ackI, ackId, cfgReq, cfgWe, cfgAddr, cfgWdata);
    mdl[1] <= stepModel(mdl[1], 2, rst, src, ackI, ackId, cfgReq, cfgWe, cfgAddr, cfgWdata);
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("irq_dut0", irq0, mdl[0].pending & mdl[0].enable);
    checkValue("irq_dut1", irq1, mdl[1].pending & mdl[1].enable);
    checkValue("rvalid_dut0", {31'd0, cfg0.cfg_rvalid}, {31'd0, mdl[0].rvalid});
    checkValue("rvalid_dut1", {31'd0, cfg1.cfg_rvalid}, {31'd0, mdl[1].rvalid});
    checkValue("rdata_dut0", cfg0.cfg_rdata, mdl[0].rdata);
    checkValue("rdata_dut1", cfg1.cfg_rdata, mdl[1].rdata);
  endtask

  // Inputs are changed at the falling edge; outputs are checked at the next one.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput();
    cfgReq = 1'b0;
    cfgWe  = 1'b0;
    ackI   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic cfgWrite(input logic [2:0] addr, input logic [31:0] data);
    cfgReq = 1'b1; cfgWe = 1'b1; cfgAddr = addr; cfgWdata = data;
    applyStimulus();
  endtask

  task automatic readExpect(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    cfgReq = 1'b1; cfgWe = 1'b0; cfgAddr = addr;
    applyStimulus();
    checkValue({tag, "_dut0"}, cfg0.cfg_rdata, exp);
    checkValue({tag, "_dut1"}, cfg1.cfg_rdata, exp);
  endtask

  task automatic ack(input logic [4:0] id);
    ackI = 1'b1; ackId = id;
    applyStimulus();
  endtask

  initial begin
    rst = 1'b1; src = '0; ackI = 1'b0; ackId = '0;
    cfgReq = 1'b0; cfgWe = 1'b0; cfgAddr = '0; cfgWdata = '0;
    idle(2);
    checkValue("reset_irq0", irq0, 32'd0);
    checkValue("reset_rvalid1", {31'd0, cfg1.cfg_rvalid}, 32'd0);
    rst = 1'b0;
    readExpect("reset_mode", 3'd2, 32'hFFFF_FFFF);

    // Basic edge delivery and ack on source 0.
    cfgWrite(3'd0, 32'h1);
    src[0] = 1'b1;
    applyStimulus();
    checkValue("edge_lat_dut0", irq0, 32'h1);
    checkValue("edge_lat_dut1_early", irq1, 32'h0);
    idle(2);
    checkValue("edge_lat_dut1", irq1, 32'h1);
    ack(5'd0);
    checkValue("ack_clr_dut0", irq0, 32'h0);
    checkValue("ack_clr_dut1", irq1, 32'h0);
    readExpect("ack_cnt1", 3'd5, 32'd1);
    readExpect("last_id0", 3'd6, 32'd0);
    src[0] = 1'b0;
    applyStimulus();

    // Repeated edges on a pending source are recorded as misses.
    cfgWrite(3'd0, 32'hFFFF_FFFF);
    for (int p = 0; p < 4; p++) begin
      src[3] = 1'b1; applyStimulus();
      src[3] = 1'b0; applyStimulus();
    end
    idle(3);
    readExpect("missed8", 3'd3, 32'h8);
    readExpect("drop3", 3'd4, 32'd3);
    cfgWrite(3'd3, 32'h8);
    readExpect("missed_w1c", 3'd3, 32'h0);
    cfgWrite(3'd1, 32'h8);

    // Ack and a new edge for the same source in one cycle.
    src[5] = 1'b1; applyStimulus();
    src[5] = 1'b0; idle(4);
    src[5] = 1'b1; ackI = 1'b1; ackId = 5'd5;
    applyStimulus();
    checkValue("ack_vs_edge_dut0", irq0 & 32'h20, 32'h20);
    idle(3);
    readExpect("drop_unchanged", 3'd4, 32'd3);
    readExpect("ack_cnt2", 3'd5, 32'd2);
    src[5] = 1'b0;
    ack(5'd5);
    idle(3);

    // Level mode ignores acks and tracks the source.
    cfgWrite(3'd2, 32'h0);
    cfgWrite(3'd0, 32'h80);
    src[7] = 1'b1; idle(3);
    ack(5'd7);
    applyStimulus();
    checkValue("level_ack_dut0", irq0, 32'h80);
    checkValue("level_ack_dut1", irq1, 32'h80);
    src[7] = 1'b0;
    applyStimulus();
    checkValue("level_fall_dut0", irq0, 32'h0);
    checkValue("level_fall_dut1_early", irq1, 32'h80);
    idle(2);
    checkValue("level_fall_dut1", irq1, 32'h0);
    cfgWrite(3'd2, 32'hFFFF_FFFF);
    cfgWrite(3'd7, 32'hDEAD_BEEF);
    cfgWrite(3'd6, 32'h1F);
    readExpect("unmapped", 3'd7, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      src = $urandom;
      if ($urandom_range(3) == 0) begin
        ackI = 1'b1; ackId = 5'($urandom_range(31));
      end
      if ($urandom_range(2) == 0) begin
        cfgReq = 1'b1; cfgWe = 1'($urandom_range(1));
        cfgAddr = 3'($urandom_range(7)); cfgWdata = $urandom;
      end
      applyStimulus();
    end

    // Drop counter saturation: alternate edges on two pending sources.
    src = '0; idle(4);
    cfgWrite(3'd2, 32'hFFFF_FFFF);
    cfgWrite(3'd0, 32'h3);
    cfgWrite(3'd1, 32'hFFFF_FFFF);
    cfgWrite(3'd3, 32'hFFFF_FFFF);
    cfgWrite(3'd4, 32'h0);
    for (int c = 0; c < 65600; c++) begin
      src = (c % 2 == 0) ? 32'h1 : 32'h2;
      applyStimulus();
    end
    src = '0; idle(4);
    readExpect("drop_sat", 3'd4, 32'h0000_FFFF);
    cfgWrite(3'd4, 32'h1234);
    readExpect("drop_clr", 3'd4, 32'h0);

    // Reset mid-operation with pending interrupts and a read issued.
    cfgWrite(3'd0, 32'hFF);
    cfgWrite(3'd1, 32'hFFFF_FFFF);
    src = 32'hFF; idle(4);
    checkValue("pre_rst_dut0", irq0, 32'hFF);
    checkValue("pre_rst_dut1", irq1, 32'hFF);
    rst = 1'b1; cfgReq = 1'b1; cfgWe = 1'b0; cfgAddr = 3'd1;
    applyStimulus();
    checkValue("rst_irq_dut0", irq0, 32'h0);
    checkValue("rst_irq_dut1", irq1, 32'h0);
    checkValue("rst_rvalid_dut1", {31'd0, cfg1.cfg_rvalid}, 32'h0);
    checkValue("rst_rdata_dut1", cfg1.cfg_rdata, 32'h0);
    rst = 1'b0;
    readExpect("rst_enable", 3'd0, 32'h0);
    readExpect("rst_ackcnt", 3'd5, 32'h0);
    idle(3);
    readExpect("post_rst_pending", 3'd1, 32'hFF);
    readExpect("post_rst_missed", 3'd3, 32'h0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
